mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multi-cycle main control FSM of the MIPS core; the stage directly upstream of ALUcontrol.
//  Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK per instruction and drives all datapath strobes.
//  Produces sig_ALUop, which feeds ALUcontrol alongside func.
//  Waits on a memory ready handshake and counts retired instructions.
// PARAMETERS
//  OPCODE_W      4   opcode width (instr field decoded in DECODE)
//  CNT_W         32  retired-instruction counter width
//  ILLEGAL_TRAP  0   0: illegal opcode -> pulse illegal, resume FETCH; 1: enter HALT until reset
// PORTS
//  clk           in   1         rising-edge clock
//  rst_n         in   1         async active-low reset
//  opcode        in   OPCODE_W  instruction opcode from IR
//  zero          in   1         ALU zero flag
//  mem_ready     in   1         memory completes current read/write this cycle
//  mem_read      out  1         memory read request
//  mem_write     out  1         memory write request
//  i_or_d        out  1         0: PC addresses memory, 1: ALUOut addresses memory
//  ir_write      out  1         load IR
//  pc_en         out  1         PC load = pc_write | (pc_write_cond & zero)
//  pc_source     out  2         00 ALU result, 01 ALUOut (branch), 10 jump target
//  alu_src_a     out  1         0: PC, 1: reg A
//  alu_src_b     out  2         00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  sig_ALUop     out  2         to ALUcontrol: 11 add, 10 sub, 01 code 010, 00 decode func
//  reg_dst       out  1         0: rt, 1: rd
//  mem_to_reg    out  1         0: ALUOut, 1: MDR
//  reg_write     out  1         register file write
//  instr_done    out  1         1-cycle pulse on last cycle of each instruction
//  illegal       out  1         1-cycle pulse in DECODE on unknown opcode
//  retired       out  CNT_W     count of completed instructions
//  halted        out  1         in HALT state
// BEHAVIOUR
//  Opcodes: 0000 R-type, 0001 LW, 0010 SW, 0011 BEQ, 0100 ADDI, 0101 ANDI, 0110 J; others illegal.
//  Moore outputs decoded from state register; opcode latched into op_q in DECODE, used afterwards.
//  Reset: state=IDLE, op_q=0, retired=0; every output 0 (sig_ALUop=00) while rst_n low.
//  IDLE -> FETCH unconditionally after 1 cycle.
//  FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALUop=11, pc_source=00;
//    ir_write=pc_write=1 only in cycle mem_ready=1, then DECODE; else hold FETCH.
//  DECODE: alu_src_a=0, alu_src_b=11, ALUop=11; next by opcode: LW/SW->MEM_ADDR, R->EXEC_R,
//    BEQ->BRANCH, ADDI/ANDI->EXEC_I, J->JUMP, illegal->FETCH (or HALT if ILLEGAL_TRAP).
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, ALUop=11; LW->MEM_RD, SW->MEM_WR.
//  MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready, then MEM_WB.
//  MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; instr_done; -> FETCH.
//  MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready; instr_done in ready cycle; -> FETCH.
//  EXEC_R: alu_src_a=1, alu_src_b=00, ALUop=00 -> R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done.
//  BRANCH: alu_src_a=1, alu_src_b=00, ALUop=10, pc_write_cond=1, pc_source=01; instr_done; -> FETCH.
//  EXEC_I: alu_src_a=1, alu_src_b=10, ALUop=11 (ADDI) or 01 (ANDI) -> I_WB: reg_write=1, reg_dst=0, instr_done.
//  JUMP: pc_write=1, pc_source=10; instr_done; -> FETCH.
//  HALT: all strobes 0, halted=1; exits only via reset.
//  retired increments on each instr_done cycle; wraps 2^CNT_W-1 -> 0; illegal not counted.
//  mem_ready ignored outside FETCH/MEM_RD/MEM_WR. mem_read and mem_write never both 1.
//  Reset asserted mid-instruction: immediate return to IDLE, no partial writes afterward.
// STRUCTURE
//  mips_ctrl_pkg: state encoding (IDLE..HALT, 4 bits), opcode constants, ALUop constants
//    (ALUOP_ADD=11, ALUOP_SUB=10, ALUOP_IMM=01, ALUOP_FUNC=00), alu_src_b/pc_source encodings.
//  One sub-module: mips_ctrl_outdec (combinational state+op_q -> control word).
// TESTING
//  rst_n low during MEM_RD -> all outputs 0 immediately; after release IDLE 1 cycle, then FETCH.
//  R-type, mem_ready=1: IDLE,FETCH,DECODE,EXEC_R,R_WB; ALUop 11,11,00,00; reg_write only in R_WB; retired=1.
//  LW, mem_ready low 3 cycles in MEM_RD -> mem_read,i_or_d held 4 cycles; reg_write+mem_to_reg 1 cycle after.
//  BEQ zero=1 -> pc_en=1, pc_source=01, ALUop=10 in BRANCH; zero=0 -> pc_en=0; retired increments both.
//  ANDI -> EXEC_I ALUop=01; ADDI -> 11; both alu_src_b=10, reg_dst=0 in I_WB.
//  Opcode 1111 -> illegal pulse in DECODE, FETCH next, retired unchanged; ILLEGAL_TRAP=1 -> halted=1, strobes 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM:
// state codes, opcodes, ALUop / mux-select values and the control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_EXEC_I   = 4'd10,
    S_I_WB     = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_SW   = 4'd2;
  localparam logic [3:0] OP_BEQ  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_ANDI = 4'd5;
  localparam logic [3:0] OP_J    = 4'd6;

  localparam logic [1:0] ALUOP_ADD  = 2'b11;
  localparam logic [1:0] ALUOP_SUB  = 2'b10;
  localparam logic [1:0] ALUOP_IMM  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b00;

  localparam logic [1:0] ASB_REG_B   = 2'b00;
  localparam logic [1:0] ASB_FOUR    = 2'b01;
  localparam logic [1:0] ASB_IMM     = 2'b10;
  localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal;
    logic       halted;
  } ctrl_word_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Control-word decoder: maps the current FSM state (plus latched opcode and
// the memory handshake) onto every datapath strobe.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  state_t              state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [OPCODE_W-1:0] op_q,
  input  logic                mem_ready,
  output ctrl_word_t          cw
);

  // Moore decode; only FETCH/MEM_WR strobes qualify on mem_ready
  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = ASB_FOUR;
        cw.alu_op    = ALUOP_ADD;
        cw.pc_source = PCS_ALU;
        if (mem_ready) begin
          cw.ir_write = 1'b1;
          cw.pc_write = 1'b1;
        end else begin
          cw.ir_write = 1'b0;
          cw.pc_write = 1'b0;
        end
      end
      S_DECODE: begin
        cw.alu_src_b = ASB_IMM_SH2;
        cw.alu_op    = ALUOP_ADD;
        cw.illegal   = (opcode > OPCODE_W'(OP_J));
      end
      S_MEM_ADDR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = ASB_IMM;
        cw.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        cw.mem_read = 1'b1;
        cw.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        cw.mem_write  = 1'b1;
        cw.i_or_d     = 1'b1;
        cw.instr_done = mem_ready;
      end
      S_EXEC_R: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = ASB_REG_B;
        cw.alu_op    = ALUOP_FUNC;
      end
      S_R_WB: begin
        cw.reg_write  = 1'b1;
        cw.reg_dst    = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_src_b     = ASB_REG_B;
        cw.alu_op        = ALUOP_SUB;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = PCS_ALUOUT;
        cw.instr_done    = 1'b1;
      end
      S_EXEC_I: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = ASB_IMM;
        cw.alu_op    = (op_q == OPCODE_W'(OP_ANDI)) ? ALUOP_IMM : ALUOP_ADD;
      end
      S_I_WB: begin
        cw.reg_write  = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_JUMP: begin
        cw.pc_write   = 1'b1;
        cw.pc_source  = PCS_JUMP;
        cw.instr_done = 1'b1;
      end
      S_HALT: begin
        cw.halted = 1'b1;
      end
      default: begin
        cw = '0;
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences each instruction, drives the
// datapath strobes and sig_ALUop for ALUcontrol, and counts retired instructions.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W     = 4,
  parameter int CNT_W        = 32,
  parameter int ILLEGAL_TRAP = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_en,
  output logic [1:0]          pc_source,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          sig_ALUop,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                instr_done,
  output logic                illegal,
  output logic                halted,
  output logic [CNT_W-1:0]    retired
);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [OPCODE_W-1:0] op_q;
  logic [CNT_W-1:0]    retired_r;
  ctrl_word_t          cw_s;

  mips_ctrl_outdec #(.OPCODE_W(OPCODE_W)) u_outdec (
    .state     (state_r),
    .opcode    (opcode),
    .op_q      (op_q),
    .mem_ready (mem_ready),
    .cw        (cw_s)
  );

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:     state_nxt_s = S_FETCH;
      S_FETCH:    state_nxt_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OPCODE_W'(OP_R):                     state_nxt_s = S_EXEC_R;
          OPCODE_W'(OP_LW), OPCODE_W'(OP_SW):  state_nxt_s = S_MEM_ADDR;
          OPCODE_W'(OP_BEQ):                   state_nxt_s = S_BRANCH;
          OPCODE_W'(OP_ADDI), OPCODE_W'(OP_ANDI): state_nxt_s = S_EXEC_I;
          OPCODE_W'(OP_J):                     state_nxt_s = S_JUMP;
          default: state_nxt_s = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_nxt_s = (op_q == OPCODE_W'(OP_SW)) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_nxt_s = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_nxt_s = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   state_nxt_s = S_R_WB;
      S_EXEC_I:   state_nxt_s = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_nxt_s = S_FETCH;
      S_HALT:     state_nxt_s = S_HALT;
      default:    state_nxt_s = S_IDLE;
    endcase
  end

  // State, latched opcode and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      op_q      <= '0;
      retired_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == S_DECODE) begin
        op_q <= opcode;
      end else begin
        op_q <= op_q;
      end
      if (cw_s.instr_done) begin
        retired_r <= retired_r + CNT_W'(1);
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  assign mem_read   = cw_s.mem_read;
  assign mem_write  = cw_s.mem_write;
  assign i_or_d     = cw_s.i_or_d;
  assign ir_write   = cw_s.ir_write;
  assign pc_en      = cw_s.pc_write | (cw_s.pc_write_cond & zero);
  assign pc_source  = cw_s.pc_source;
  assign alu_src_a  = cw_s.alu_src_a;
  assign alu_src_b  = cw_s.alu_src_b;
  assign sig_ALUop  = cw_s.alu_op;
  assign reg_dst    = cw_s.reg_dst;
  assign mem_to_reg = cw_s.mem_to_reg;
  assign reg_write  = cw_s.reg_write;
  assign instr_done = cw_s.instr_done;
  assign illegal    = cw_s.illegal;
  assign halted     = cw_s.halted;
  assign retired    = retired_r;

endmodule
